// File: rtl/muldiv_pkg.sv
// Shared constants for the integer pipeline.
// Holds the base opcode/ALU encodings, the RV32M funct3 encodings used by
// the iterative multiply/divide unit, the state constants for its FSM and
// small decode helpers so every consumer classifies an op the same way.
package muldiv_pkg;

  // Base opcode and funct7 values that route an instruction to this unit
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Existing single-cycle ALU encodings
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_e;

  // FSM state encoding of the multiply/divide unit
  typedef logic [1:0] muldiv_state_t;
  localparam muldiv_state_t ST_IDLE = 2'b00;
  localparam muldiv_state_t ST_BUSY = 2'b01;
  localparam muldiv_state_t ST_DONE = 2'b10;

  // Divide-family ops (quotient or remainder)
  function automatic logic op_is_div(input muldiv_op_e op);
    case (op)
      MD_DIV, MD_DIVU, MD_REM, MD_REMU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  // Ops that return the remainder
  function automatic logic op_is_rem(input muldiv_op_e op);
    case (op)
      MD_REM, MD_REMU: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  // Multiplies that return the upper half of the double-width product
  function automatic logic op_mul_high(input muldiv_op_e op);
    case (op)
      MD_MULH, MD_MULHSU, MD_MULHU: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  // Operand A is interpreted as two's complement. MUL is treated as
  // unsigned: its low half is identical either way.
  function automatic logic op_a_signed(input muldiv_op_e op);
    case (op)
      MD_MULH, MD_MULHSU, MD_DIV, MD_REM: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Operand B is interpreted as two's complement
  function automatic logic op_b_signed(input muldiv_op_e op);
    case (op)
      MD_MULH, MD_DIV, MD_REM: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling around the unsigned multiply/divide core.
// Produces operand magnitudes and the sign the final result must carry,
// and negates a double-width raw result when requested.
// Ports:
//   i_op      : op being accepted (selects which operands are signed)
//   i_a, i_b  : raw operands
//   o_a_mag   : |A| (or A when A is treated as unsigned)
//   o_b_mag   : |B| (or B when B is treated as unsigned)
//   o_neg_res : the magnitude result must be negated
//   i_raw     : double-width unsigned result from the core
//   i_neg     : negate i_raw
//   o_fixed   : i_raw, two's-complement negated when i_neg is set
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  muldiv_op_e          i_op,
  input  logic [DWIDTH-1:0]   i_a,
  input  logic [DWIDTH-1:0]   i_b,
  output logic [DWIDTH-1:0]   o_a_mag,
  output logic [DWIDTH-1:0]   o_b_mag,
  output logic                o_neg_res,
  input  logic [2*DWIDTH-1:0] i_raw,
  input  logic                i_neg,
  output logic [2*DWIDTH-1:0] o_fixed
);

  logic w_a_neg;
  logic w_b_neg;

  // Operand magnitudes and result sign
  always_comb begin
    w_a_neg = op_a_signed(i_op) & i_a[DWIDTH-1];
    w_b_neg = op_b_signed(i_op) & i_b[DWIDTH-1];
    // The most-negative value maps onto itself, which is its correct
    // unsigned magnitude.
    if (w_a_neg) begin
      o_a_mag = ~i_a + DWIDTH'(1);
    end else begin
      o_a_mag = i_a;
    end
    if (w_b_neg) begin
      o_b_mag = ~i_b + DWIDTH'(1);
    end else begin
      o_b_mag = i_b;
    end
    // Remainder follows the dividend; products and quotients follow the
    // XOR of operand signs.
    case (i_op)
      MD_MULH, MD_MULHSU, MD_DIV: o_neg_res = w_a_neg ^ w_b_neg;
      MD_REM:                     o_neg_res = w_a_neg;
      default:                    o_neg_res = 1'b0;
    endcase
  end

  // Result negation over the full double width so the upper product
  // half receives the correct borrow.
  always_comb begin
    if (i_neg) begin
      o_fixed = ~i_raw + (2*DWIDTH)'(1);
    end else begin
      o_fixed = i_raw;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide on magnitudes, one
// iteration per cycle for DWIDTH cycles. Divide-by-zero and signed
// overflow finish in a single cycle.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-low reset
//   start_i    : request an op (taken only when idle and not flushing)
//   flush_i    : abort the in-flight op; wins over start_i
//   funct3_i   : RV32M op select (muldiv_op_e)
//   rs1_i/rs2_i: operands A / B
//   busy_o     : FSM not idle
//   valid_o    : one-cycle result strobe
//   res_o      : result, held until the next strobe
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic [DWIDTH-1:0] rs2_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [DWIDTH-1:0] res_o
);

  localparam int CW = $clog2(DWIDTH);
  localparam logic [CW-1:0]     LAST_CNT = CW'(DWIDTH - 1);
  localparam logic [DWIDTH-1:0] ZERO     = {DWIDTH{1'b0}};
  localparam logic [DWIDTH-1:0] ALL_ONES = {DWIDTH{1'b1}};
  localparam logic [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

  muldiv_state_t       r_state;
  logic [CW-1:0]       r_cnt;
  muldiv_op_e          r_op;
  // Upper half: product high / partial remainder.
  // Lower half: multiplier being shifted out / quotient being shifted in.
  logic [2*DWIDTH-1:0] r_acc;
  logic [DWIDTH-1:0]   r_opb;
  logic                r_neg;
  logic                r_fast;
  logic                r_valid;
  logic [DWIDTH-1:0]   r_res;

  muldiv_op_e          w_op;
  logic                w_accept;
  logic                w_div_zero;
  logic                w_ovf;
  logic                w_fast;
  logic [DWIDTH-1:0]   w_fast_res;
  logic [DWIDTH-1:0]   w_a_mag;
  logic [DWIDTH-1:0]   w_b_mag;
  logic                w_neg_res;
  logic [DWIDTH:0]     w_mul_sum;
  logic [DWIDTH:0]     w_div_shift;
  logic                w_div_ge;
  logic [DWIDTH-1:0]   w_div_diff;
  logic [2*DWIDTH-1:0] w_acc_next;
  logic [2*DWIDTH-1:0] w_raw;
  logic [2*DWIDTH-1:0] w_fixed;
  logic [DWIDTH-1:0]   w_iter_res;

  assign w_op     = muldiv_op_e'(funct3_i);
  assign w_accept = start_i & ~flush_i & (r_state == ST_IDLE);
  assign w_fast   = w_div_zero | w_ovf;

  muldiv_signfix #(
    .DWIDTH (DWIDTH)
  ) u_signfix (
    .i_op      (w_op),
    .i_a       (rs1_i),
    .i_b       (rs2_i),
    .o_a_mag   (w_a_mag),
    .o_b_mag   (w_b_mag),
    .o_neg_res (w_neg_res),
    .i_raw     (w_raw),
    .i_neg     (r_neg),
    .o_fixed   (w_fixed)
  );

  // Single-cycle cases: divide by zero and signed DIV/REM overflow
  always_comb begin
    if (op_is_div(w_op)) begin
      w_div_zero = (rs2_i == ZERO);
      w_ovf      = op_b_signed(w_op) & (rs1_i == MOST_NEG) & (rs2_i == ALL_ONES);
    end else begin
      w_div_zero = 1'b0;
      w_ovf      = 1'b0;
    end
    if (w_div_zero) begin
      w_fast_res = op_is_rem(w_op) ? rs1_i : ALL_ONES;
    end else if (w_ovf) begin
      w_fast_res = op_is_rem(w_op) ? ZERO : rs1_i;
    end else begin
      w_fast_res = ZERO;
    end
  end

  // One shift-add or restoring-divide step on r_acc
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*DWIDTH-1:DWIDTH]} + {1'b0, (r_acc[0] ? r_opb : ZERO)};
    // Partial remainder shifted left with the next dividend bit
    w_div_shift = r_acc[2*DWIDTH-1:DWIDTH-1];
    w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    // The difference always fits DWIDTH bits when it is kept
    w_div_diff  = w_div_shift[DWIDTH-1:0] - r_opb;
    if (op_is_div(r_op)) begin
      if (w_div_ge) begin
        w_acc_next = {w_div_diff, r_acc[DWIDTH-2:0], 1'b1};
      end else begin
        w_acc_next = {w_div_shift[DWIDTH-1:0], r_acc[DWIDTH-2:0], 1'b0};
      end
    end else begin
      w_acc_next = {w_mul_sum, r_acc[DWIDTH-1:1]};
    end
  end

  // Final result from the last iteration's accumulator value
  always_comb begin
    if (op_is_rem(r_op)) begin
      w_raw = {ZERO, w_acc_next[2*DWIDTH-1:DWIDTH]};
    end else if (op_is_div(r_op)) begin
      w_raw = {ZERO, w_acc_next[DWIDTH-1:0]};
    end else begin
      w_raw = w_acc_next;
    end
    if (op_mul_high(r_op)) begin
      w_iter_res = w_fixed[2*DWIDTH-1:DWIDTH];
    end else begin
      w_iter_res = w_fixed[DWIDTH-1:0];
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_op    <= MD_MUL;
      r_acc   <= {2*DWIDTH{1'b0}};
      r_opb   <= ZERO;
      r_neg   <= 1'b0;
      r_fast  <= 1'b0;
      r_valid <= 1'b0;
      r_res   <= ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_valid <= 1'b0;
          if (w_accept) begin
            r_state <= ST_BUSY;
            r_op    <= w_op;
            r_cnt   <= {CW{1'b0}};
            if (w_fast) begin
              // Park the finished answer; it is published next edge
              r_fast <= 1'b1;
              r_neg  <= 1'b0;
              r_opb  <= ZERO;
              r_acc  <= {ZERO, w_fast_res};
            end else begin
              // Multiply and divide share the same starting layout
              r_fast <= 1'b0;
              r_neg  <= w_neg_res;
              r_opb  <= w_b_mag;
              r_acc  <= {ZERO, w_a_mag};
            end
          end
        end
        ST_BUSY: begin
          if (flush_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_fast  <= 1'b0;
            r_valid <= 1'b0;
          end else if (r_fast) begin
            r_state <= ST_DONE;
            r_fast  <= 1'b0;
            r_valid <= 1'b1;
            r_res   <= r_acc[DWIDTH-1:0];
          end else begin
            r_acc <= w_acc_next;
            if (r_cnt == LAST_CNT) begin
              r_state <= ST_DONE;
              r_cnt   <= {CW{1'b0}};
              r_valid <= 1'b1;
              r_res   <= w_iter_res;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= {CW{1'b0}};
          r_fast  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = (r_state != ST_IDLE);
  assign valid_o = r_valid;
  assign res_o   = r_res;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] rs1_i = 32'd0;
  logic [31:0] rs2_i = 32'd0;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] res_o;

  muldiv_unit #(.DWIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .res_o    (res_o)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  // Model of the single outstanding op: accepted at edge m_acc, result
  // published at edge m_done, optionally killed at edge m_kill.
  bit          m_active = 1'b0;
  int          m_acc = 0;
  int          m_done = 0;
  int          m_kill = 32'h3fffffff;
  logic [31:0] m_res_next = 32'd0;
  logic [31:0] m_res_prev = 32'd0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
  endtask

  // Architectural RV32M result from plain 64-bit arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, t;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h80000000) && (b == 32'hffffffff);
    case (op)
      3'd0: begin t = sa * sb; p = t; return p[31:0]; end
      3'd1: begin t = sa * sb; p = t; return p[63:32]; end
      3'd2: begin t = sa * ub; p = t; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hffffffff;
        if (ovf) return a;
        t = sa / sb; p = t; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hffffffff : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        t = sa % sb; p = t; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Edges from accept to the result edge
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 32'd0)) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hffffffff) return 1;
    return 32;
  endfunction

  function automatic void model_retire();
    if (m_active && (cyc > m_done || cyc >= m_kill)) begin
      if (m_kill > m_done) m_res_prev = m_res_next;
      m_active = 1'b0;
    end
  endfunction

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic        e_busy;
    logic        e_valid;
    logic [31:0] e_res;
    if (chk_en) begin
      model_retire();
      e_busy  = m_active && cyc >= m_acc && cyc <= m_done && cyc < m_kill;
      e_valid = m_active && cyc == m_done && cyc < m_kill;
      e_res   = (m_active && cyc >= m_done && cyc < m_kill) ? m_res_next : m_res_prev;
      chk("busy_o", {31'd0, busy_o}, {31'd0, e_busy});
      chk("valid_o", {31'd0, valid_o}, {31'd0, e_valid});
      chk("res_o", res_o, e_res);
    end
  end

  // Present one request for one cycle; returns at the negedge after accept
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    model_retire();
    funct3_i   = op;
    rs1_i      = a;
    rs2_i      = b;
    start_i    = 1'b1;
    m_acc      = cyc + 1;
    m_done     = m_acc + ref_lat(op, a, b);
    m_kill     = 32'h3fffffff;
    m_res_next = ref_res(op, a, b);
    m_active   = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    funct3_i = 3'($urandom);
    rs1_i    = $urandom;
    rs2_i    = $urandom;
  endtask

  task automatic wait_done();
    while (cyc <= m_done) @(negedge clk);
  endtask

  task automatic run_pinned(input string nm, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] lit);
    chk({nm, "_model"}, ref_res(op, a, b), lit);
    issue(op, a, b);
    while (cyc < m_done) @(negedge clk);
    chk({nm, "_valid"}, {31'd0, valid_o}, 32'd1);
    chk(nm, res_o, lit);
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int sel;
    logic [2:0]  op;
    logic [31:0] a, b;

    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_valid", {31'd0, valid_o}, 32'd0);
    chk("reset_res", res_o, 32'd0);
    #2 rst = 1'b1;
    chk_en = 1'b1;

    chk("lat_mul", ref_lat(3'd0, 32'd7, 32'd3), 32'd32);
    chk("lat_div0", ref_lat(3'd5, 32'd9, 32'd0), 32'd1);

    run_pinned("mul",     3'd0, 32'd7,        32'hfffffffd, 32'hffffffeb);
    run_pinned("mulh",    3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
    run_pinned("mulhu",   3'd3, 32'hffffffff, 32'hffffffff, 32'hfffffffe);
    run_pinned("mulhsu",  3'd2, 32'hffffffff, 32'hffffffff, 32'hffffffff);
    run_pinned("div",     3'd4, 32'hffffffec, 32'd6,        32'hfffffffd);
    run_pinned("rem",     3'd6, 32'hffffffec, 32'd6,        32'hfffffffe);
    run_pinned("divu",    3'd5, 32'd20,       32'd6,        32'd3);
    run_pinned("remu",    3'd7, 32'd20,       32'd6,        32'd2);
    run_pinned("divu_z",  3'd5, 32'd9,        32'd0,        32'hffffffff);
    run_pinned("rem_z",   3'd6, 32'd5,        32'd0,        32'd5);
    run_pinned("div_ovf", 3'd4, 32'h80000000, 32'hffffffff, 32'h80000000);
    run_pinned("rem_ovf", 3'd6, 32'h80000000, 32'hffffffff, 32'd0);

    // start_i held high with junk operands through BUSY and DONE
    issue(3'd5, $urandom, $urandom_range(1, 1000));
    while (cyc <= m_done) begin
      start_i  = 1'b1;
      funct3_i = 3'($urandom);
      rs1_i    = $urandom;
      rs2_i    = $urandom;
      @(negedge clk);
    end
    start_i = 1'b0;

    // flush_i beats start_i in the same idle cycle
    @(negedge clk);
    model_retire();
    start_i = 1'b1;
    flush_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    chk("flush_prio_busy", {31'd0, busy_o}, 32'd0);

    // Flush at iteration 10
    issue(3'd3, $urandom, $urandom);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    m_kill  = cyc + 1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    repeat (30) @(negedge clk);
    run_pinned("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12);

    // Randomized ops, biased toward the corner cases
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h80000000; b = 32'hffffffff; end
      else if (sel == 2) begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
      else if (sel == 3) begin a = -$urandom_range(0, 50); b = -$urandom_range(1, 9); end
      issue(op, a, b);
      wait_done();
    end

    // Asynchronous reset at iteration 15
    issue(3'd1, $urandom, $urandom);
    repeat (15) @(negedge clk);
    #2 rst = 1'b0;
    m_active   = 1'b0;
    m_res_prev = 32'd0;
    #1;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_res", res_o, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
